sc_fifo_stream_reader: RTL and testbench

SC_FIFO_STREAM_READER -- requirements
Module: sc_fifo_stream_reader

---
 rtl/sc_fifo_stream_reader.sv | 129 ++++++++++++
 tb/tb_sc_fifo_stream_reader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_fifo_stream_reader.sv
// ============================================================================
// Module   : sc_fifo_stream_reader
// Function : Pops a show-ahead FIFO into a valid/ready stream through a
//            two-entry main/skid buffer.
//            Optional word counter when SC_FIFO_STREAM_READER_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_fifo_stream_reader #(
    parameter int DATA_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              fifo_rd_en_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        level_o
`ifdef SC_FIFO_STREAM_READER_CNT_EN
    ,
    output logic [31:0]       word_cnt_o
`endif
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              pop;
    logic              fire;
    logic              load_main_fifo;
    logic              load_main_skid;
    logic              load_skid;

    // Gating with rst_n_i keeps the FIFO untouched while reset is held.
    assign pop  = rst_n_i & en_i & ~fifo_empty_i & (state_q != S_TWO);
    assign fire = (state_q != S_EMPTY) & ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_fifo = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (pop) begin
                    state_d        = S_ONE;
                    load_main_fifo = 1'b1;
                end
            end
            S_ONE: begin
                if (pop && fire) begin
                    load_main_fifo = 1'b1;
                end else if (pop) begin
                    state_d   = S_TWO;
                    load_skid = 1'b1;
                end else if (fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (fire) begin
                    state_d        = S_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        fifo_rd_en_o = pop;
        valid_o      = (state_q != S_EMPTY);
        data_o       = main_q;
        case (state_q)
            S_ONE:   level_o = 2'd1;
            S_TWO:   level_o = 2'd2;
            default: level_o = 2'd0;
        endcase
    end

    // Data registers carry no reset; their contents only matter under state_q.
    always_ff @(posedge clk_i) begin
        if (load_main_fifo) begin
            main_q <= fifo_data_i;
        end else if (load_main_skid) begin
            main_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= fifo_data_i;
        end
    end

`ifdef SC_FIFO_STREAM_READER_CNT_EN
    logic [31:0] word_cnt_q;
    logic [31:0] word_cnt_d;

    assign word_cnt_d = fire ? (word_cnt_q + 32'd1) : word_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            word_cnt_q <= 32'd0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt_o = word_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sc_fifo_stream_reader.sv
// ============================================================================
// Module   : tb_sc_fifo_stream_reader
// Function : Directed self-checking bench for sc_fifo_stream_reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sc_fifo_stream_reader;

    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd_en;
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [1:0]        level;
`ifdef SC_FIFO_STREAM_READER_CNT_EN
    logic [31:0]       word_cnt;
`endif

    logic [DATA_W-1:0] mem [0:31];
    int                head;
    int                tail;
    int                n_cmp;
    int                n_fail;
    int                snap;

    sc_fifo_stream_reader #(.DATA_W(DATA_W)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .en_i         (en),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_rd_en_o (fifo_rd_en),
        .valid_o      (valid),
        .ready_i      (ready),
        .data_o       (data),
        .level_o      (level)
`ifdef SC_FIFO_STREAM_READER_CNT_EN
        ,
        .word_cnt_o   (word_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Show-ahead FIFO model; head doubles as the running pop count.
    assign fifo_empty = (head == tail);
    assign fifo_data  = mem[head[4:0]];

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            head <= head + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        mem[tail[4:0]] = w;
        tail = tail + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        ready = 1'b0;
        push(32'h11);
        step();
        n_cmp++;
        if (fifo_rd_en !== 1'b0 || valid !== 1'b0 || level !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_hold: rd_en=%b valid=%b level=%0d, need 0/0/0", fifo_rd_en, valid, level);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (fifo_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL first_pop: rd_en=%b, need 1", fifo_rd_en);
        end
        step();
        n_cmp++;
        if (valid !== 1'b1 || data !== 32'h11 || level !== 2'd1) begin
            n_fail++;
            $display("FAIL first_word: valid=%b data=%h level=%0d, need 1/11/1", valid, data, level);
        end
        ready = 1'b1;
        step();
        n_cmp++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_drain: valid=%b, need 0", valid);
        end
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] exp_w [0:2];
        exp_w[0] = 32'hA;
        exp_w[1] = 32'hB;
        exp_w[2] = 32'hC;
        ready = 1'b1;
        push(32'hA);
        push(32'hB);
        push(32'hC);
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (valid !== 1'b1 || data !== exp_w[i]) begin
                n_fail++;
                $display("FAIL stream_%0d: valid=%b data=%h, need 1/%h", i, valid, data, exp_w[i]);
            end
        end
        step();
        n_cmp++;
        if (valid !== 1'b0 || level !== 2'd0) begin
            n_fail++;
            $display("FAIL stream_end: valid=%b level=%0d, need 0/0", valid, level);
        end
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        snap  = head;
        push(32'h1);
        push(32'h2);
        push(32'h3);
        push(32'h4);
        step();
        step();
        step();
        n_cmp++;
        if (level !== 2'd2 || fifo_rd_en !== 1'b0 || (head - snap) !== 2) begin
            n_fail++;
            $display("FAIL bp_full: level=%0d rd_en=%b pops=%0d, need 2/0/2", level, fifo_rd_en, head - snap);
        end
        n_cmp++;
        if (valid !== 1'b1 || data !== 32'h1) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b data=%h, need 1/1", valid, data);
        end
        ready = 1'b1;
        step();
        n_cmp++;
        if (data !== 32'h2 || level !== 2'd1 || fifo_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_skid: data=%h level=%0d rd_en=%b, need 2/1/1", data, level, fifo_rd_en);
        end
        step();
        n_cmp++;
        if (data !== 32'h3 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_w3: valid=%b data=%h, need 1/3", valid, data);
        end
        step();
        n_cmp++;
        if (data !== 32'h4 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_w4: valid=%b data=%h, need 1/4", valid, data);
        end
        step();
        n_cmp++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: valid=%b, need 0", valid);
        end
    endtask

    task automatic test_enable();
        ready = 1'b0;
        push(32'h5);
        push(32'h6);
        push(32'h7);
        step();
        step();
        en   = 1'b0;
        snap = head;
        #1;
        n_cmp++;
        if (fifo_rd_en !== 1'b0 || level !== 2'd2) begin
            n_fail++;
            $display("FAIL en_off: rd_en=%b level=%0d, need 0/2", fifo_rd_en, level);
        end
        ready = 1'b1;
        step();
        n_cmp++;
        if (data !== 32'h6 || level !== 2'd1 || fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drain1: data=%h level=%0d rd_en=%b, need 6/1/0", data, level, fifo_rd_en);
        end
        step();
        n_cmp++;
        if (level !== 2'd0 || valid !== 1'b0 || (head - snap) !== 0) begin
            n_fail++;
            $display("FAIL en_drain2: level=%0d valid=%b pops=%0d, need 0/0/0", level, valid, head - snap);
        end
        en = 1'b1;
        #1;
        n_cmp++;
        if (fifo_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL en_resume: rd_en=%b, need 1", fifo_rd_en);
        end
        step();
        n_cmp++;
        if (valid !== 1'b1 || data !== 32'h7) begin
            n_fail++;
            $display("FAIL en_w7: valid=%b data=%h, need 1/7", valid, data);
        end
        step();
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        push(32'h8);
        push(32'h9);
        push(32'h10);
        step();
        step();
        n_cmp++;
        if (level !== 2'd2) begin
            n_fail++;
            $display("FAIL rm_pre: level=%0d, need 2", level);
        end
        snap  = head;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (valid !== 1'b0 || level !== 2'd0 || fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_async: valid=%b level=%0d rd_en=%b, need 0/0/0", valid, level, fifo_rd_en);
        end
        step();
        n_cmp++;
        if ((head - snap) !== 0) begin
            n_fail++;
            $display("FAIL rm_nopop: pops=%0d, need 0", head - snap);
        end
`ifdef SC_FIFO_STREAM_READER_CNT_EN
        n_cmp++;
        if (word_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL cnt_reset: word_cnt=%h, need 0", word_cnt);
        end
`endif
        rst_n = 1'b1;
        ready = 1'b1;
        step();
        n_cmp++;
        if (valid !== 1'b1 || data !== 32'h10) begin
            n_fail++;
            $display("FAIL rm_next: valid=%b data=%h, need 1/10", valid, data);
        end
        step();
`ifdef SC_FIFO_STREAM_READER_CNT_EN
        n_cmp++;
        if (word_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL cnt_one: word_cnt=%h, need 1", word_cnt);
        end
`endif
    endtask

    task automatic test_counter();
`ifdef SC_FIFO_STREAM_READER_CNT_EN
        ready = 1'b0;
        push(32'h55);
        step();
        force dut.word_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.word_cnt_q;
        #1;
        n_cmp++;
        if (word_cnt !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL cnt_preload: word_cnt=%h, need ffffffff", word_cnt);
        end
        ready = 1'b1;
        step();
        n_cmp++;
        if (word_cnt !== 32'd0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cnt_wrap: word_cnt=%h valid=%b, need 0/0", word_cnt, valid);
        end
`endif
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        head   = 0;
        tail   = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        ready  = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_enable();
        test_reset_mid();
        test_counter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
